rx_word_assembler: RTL and testbench
====================================

# rx_word_assembler

Parametrised byte-to-word assembler between the UART receiver and the debug/loader logic of the pipeline. It collects BYTES_PER_WORD consecutive received bytes into one word, in either byte order, and queues completed words in a small FIFO with a valid/ready output handshake. It also offers synchronous flush, overflow detection and an optional inter-byte timeout that discards stale partial words.

## Interface
- BYTES_PER_WORD, 4, bytes per assembled word; legal range 1..8; word width W = 8*BYTES_PER_WORD
- MSB_FIRST, 1, 1: first byte lands in [W-1:W-8]; 0: first byte lands in [7:0]
- FIFO_DEPTH, 2, completed-word FIFO entries; power of two, at least 2
- TIMEOUT_CYCLES, 1000, idle cycles after which a partial word is discarded; only used with RX_ASM_TIMEOUT_EN
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- byte_valid  in  1  one-cycle strobe: byte_in holds a received byte
- byte_in  in  8  received byte
- flush  in  1  synchronous clear of partial word, FIFO and overflow
- word_valid  out  1  FIFO head holds a word
- word_ready  in  1  consumer accepts head when high together with word_valid
- word_out  out  W  FIFO head word; forced to 0 while word_valid=0
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of queued words
- busy  out  1  partial word in progress (byte index != 0)
- overflow  out  1  sticky: a completed word was dropped because the FIFO was full
- timeout_err  out  1  one-cycle pulse: a partial word was discarded by timeout

## Operation
- Reset (reset=0): byte index 0, partial register 0, FIFO empty. Outputs: word_valid 0, word_out 0, fifo_level 0, busy 0, overflow 0, timeout_err 0.
- States: IDLE (index 0) and COLLECT (index 1..BYTES_PER_WORD-1); busy = state is COLLECT.
- Accepted byte k (0-based): MSB_FIRST=1 writes bits [W-1-8k : W-8-8k]; MSB_FIRST=0 writes bits [8k+7 : 8k]. Index increments.
- Byte k = BYTES_PER_WORD-1 completes the word: assembled word (with this byte merged) is pushed, index returns to 0 (IDLE). BYTES_PER_WORD=1: every byte is a word; busy stays 0.
- Push when FIFO full and no pop in the same cycle: word dropped, overflow set, index still returns to 0.
- Push and pop in the same cycle are both performed, including when full; fifo_level unchanged.
- Pop occurs on word_valid && word_ready; pop on empty is ignored.
- flush has priority over everything else in its cycle: the byte presented with flush is discarded, index 0, FIFO emptied, overflow cleared, no timeout_err.
- overflow is cleared only by reset or flush.

## Timing
- Completed word: word_valid and fifo_level update on the clock edge that captures the last byte; visible the following cycle. Latency from last byte_valid to word_valid is 1 cycle.
- FIFO is show-ahead: word_out is valid combinationally from the head whenever word_valid=1.
- Back-to-back byte_valid on consecutive cycles is supported, one byte per cycle.
- Timeout (macro enabled): counter resets on every accepted byte and while in IDLE. It increments each COLLECT cycle without byte_valid. On reaching TIMEOUT_CYCLES: partial discarded, index 0, timeout_err high for exactly that next cycle. A byte arriving in the cycle the count would expire is accepted and restarts the counter.
- Reset asserted mid-word or with words queued: all state is cleared immediately and asynchronously; queued words are lost.

## Configuration
- RX_ASM_TIMEOUT_EN defined: the timeout counter of width $clog2(TIMEOUT_CYCLES+1) and the timeout_err logic are compiled in.
- Not defined: no counter is built. Partial words persist indefinitely until completed, flushed or reset. timeout_err is tied to 0 and TIMEOUT_CYCLES is ignored.

## Test plan
- Defaults, word_ready=1, bytes 0x12,0x34,0x56,0x78 on consecutive cycles -> word_valid high 1 cycle after the 4th byte with word_out=0x12345678; busy high after byte 1 until completion.
- MSB_FIRST=0, same bytes -> word_out=0x78563412.
- word_ready=0, send 3 complete words with FIFO_DEPTH=2 -> fifo_level=2, overflow=1, then pops return the first two words in order; flush clears overflow and fifo_level.
- FIFO full with word_ready=1 in the same cycle the last byte of a new word arrives -> no overflow, fifo_level stays 2, new word queued behind.
- Macro on, TIMEOUT_CYCLES=10, send 0xAA,0xBB then idle -> timeout_err pulse 10 cycles after 0xBB, busy drops. Next 4 bytes 0x01..0x04 -> word_out=0x01020304.
- Send 2 bytes, then flush concurrent with a 3rd byte -> busy=0, no word produced. Also assert reset low mid-word -> all outputs at reset values.

Source files
------------

// File: rtl/rx_word_assembler.sv
// rtl/rx_word_assembler.sv - collects received bytes into words and queues them in a show-ahead FIFO
// Optional inter-byte timeout compiled in with `define RX_ASM_TIMEOUT_EN.
module rx_word_assembler #(
    parameter int BYTES_PER_WORD = 4,
    parameter int MSB_FIRST      = 1,
    parameter int FIFO_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 1000,
    localparam int W             = 8 * BYTES_PER_WORD,
    localparam int LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             byte_valid,
    input  logic [7:0]       byte_in,
    input  logic             flush,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [W-1:0]     word_out,
    output logic [LVL_W-1:0] fifo_level,
    output logic             busy,
    output logic             overflow,
    output logic             timeout_err
);

    localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

    logic [0:0]       state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] lane;
    logic [W-1:0]     partial;
    logic [W-1:0]     merged;
    logic [W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;

    logic accept;
    logic last_byte;
    logic push;
    logic pop;
    logic full;
    logic push_ok;
    logic expire;

    assign accept    = byte_valid & ~flush;
    assign last_byte = (idx == LAST_IDX);
    assign push      = accept & last_byte;
    assign pop       = word_valid & word_ready & ~flush;
    assign full      = (level == LVL_W'(FIFO_DEPTH));
    // a full FIFO still takes the new word when its head leaves in the same cycle
    assign push_ok   = push & (~full | pop);

    assign lane = (MSB_FIRST != 0) ? (LAST_IDX - idx) : idx;

    always_comb begin
        merged = partial;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (lane == IDX_W'(k)) begin
                merged[8*k +: 8] = byte_in;
            end
        end
    end

`ifdef RX_ASM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            to_pulse;

    // a byte in the expiring cycle wins, so expiry needs an empty input slot
    assign expire = (state == ST_COLLECT) & ~byte_valid & ~flush &
                    (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt   <= '0;
            to_pulse <= 1'b0;
        end else begin
            to_pulse <= expire;
            if (flush || byte_valid || state == ST_IDLE || expire) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    assign timeout_err = to_pulse;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign expire             = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            idx      <= '0;
            partial  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            state    <= ST_IDLE;
            idx      <= '0;
            partial  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (expire) begin
                state   <= ST_IDLE;
                idx     <= '0;
                partial <= '0;
            end else if (accept) begin
                if (last_byte) begin
                    state   <= ST_IDLE;
                    idx     <= '0;
                    partial <= '0;
                end else begin
                    state   <= ST_COLLECT;
                    idx     <= idx + 1'b1;
                    partial <= merged;
                end
            end

            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push_ok) begin
                level <= level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= merged;
        end
    end

    assign word_valid = (level != '0);
    assign word_out   = word_valid ? mem[rd_ptr] : '0;
    assign fifo_level = level;
    assign busy       = (state == ST_COLLECT);

endmodule

// File: tb/tb_rx_word_assembler.sv
// tb/tb_rx_word_assembler.sv - randomized bench for rx_word_assembler against a queue-based reference model
module tb_rx_word_assembler;

    localparam int BPW   = 4;
    localparam int DEPTH = 2;
    localparam int TMO   = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        byte_valid;
    logic [7:0]  byte_in;
    logic        flush;
    logic        word_ready;

    logic        wv_m, busy_m, ovf_m, tmo_m;
    logic [31:0] wo_m;
    logic [1:0]  lvl_m;
    logic        wv_l, busy_l, ovf_l, tmo_l;
    logic [31:0] wo_l;
    logic [1:0]  lvl_l;

    int passed = 0;
    int total  = 0;

    logic [7:0]  byte_q [$];
    logic [31:0] qm [$];
    logic [31:0] ql [$];
    logic        m_ovf;
    logic        m_tmo;
    int          m_idle;

    always #5 clk = ~clk;

    rx_word_assembler #(
        .BYTES_PER_WORD(BPW), .MSB_FIRST(1), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
    ) dut_msb (
        .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_in(byte_in), .flush(flush),
        .word_valid(wv_m), .word_ready(word_ready), .word_out(wo_m), .fifo_level(lvl_m),
        .busy(busy_m), .overflow(ovf_m), .timeout_err(tmo_m)
    );

    rx_word_assembler #(
        .BYTES_PER_WORD(BPW), .MSB_FIRST(0), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
    ) dut_lsb (
        .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_in(byte_in), .flush(flush),
        .word_valid(wv_l), .word_ready(word_ready), .word_out(wo_l), .fifo_level(lvl_l),
        .busy(busy_l), .overflow(ovf_l), .timeout_err(tmo_l)
    );

    function automatic void model_clear();
        byte_q.delete();
        qm.delete();
        ql.delete();
        m_ovf  = 1'b0;
        m_tmo  = 1'b0;
        m_idle = 0;
    endfunction

    // drive one cycle of inputs at the falling edge, advance the model, return at the next falling edge
    task automatic step(input logic bv, input logic [7:0] b, input logic fl, input logic rdy);
        logic [31:0] wm;
        logic [31:0] wl;
        byte_valid = bv;
        byte_in    = b;
        flush      = fl;
        word_ready = rdy;
        m_tmo      = 1'b0;
        if (fl) begin
            model_clear();
        end else begin
            if (rdy && qm.size() > 0) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
            if (bv) begin
                byte_q.push_back(b);
                m_idle = 0;
                if (byte_q.size() == BPW) begin
                    wm = 32'h0;
                    wl = 32'h0;
                    for (int k = 0; k < BPW; k++) begin
                        wm = (wm << 8) | 32'(byte_q[k]);
                        wl = wl + (32'(byte_q[k]) << (8 * k));
                    end
                    if (qm.size() < DEPTH) begin
                        qm.push_back(wm);
                        ql.push_back(wl);
                    end else begin
                        m_ovf = 1'b1;
                    end
                    byte_q.delete();
                end
            end else if (byte_q.size() > 0) begin
`ifdef RX_ASM_TIMEOUT_EN
                m_idle++;
                if (m_idle == TMO) begin
                    byte_q.delete();
                    m_idle = 0;
                    m_tmo  = 1'b1;
                end
`endif
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; byte_valid = 1'b0; byte_in = 8'h0; flush = 1'b0; word_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({wv_m, wo_m, lvl_m, busy_m, ovf_m, tmo_m} !== 38'h0)
            $display("FAIL reset_msb: got %h expected 0", {wv_m, wo_m, lvl_m, busy_m, ovf_m, tmo_m});
        else passed++;
        total++;
        if ({wv_l, wo_l, lvl_l, busy_l, ovf_l, tmo_l} !== 38'h0)
            $display("FAIL reset_lsb: got %h expected 0", {wv_l, wo_l, lvl_l, busy_l, ovf_l, tmo_l});
        else passed++;
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] seq [4];
        seq[0] = 8'h12; seq[1] = 8'h34; seq[2] = 8'h56; seq[3] = 8'h78;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, seq[i], 1'b0, 1'b1);
            total++;
            if (busy_m !== (i < 3) || busy_l !== (i < 3))
                $display("FAIL basic_busy byte %0d: got %b/%b expected %b", i, busy_m, busy_l, i < 3);
            else passed++;
        end
        total++;
        if (wv_m !== 1'b1 || wo_m !== 32'h12345678)
            $display("FAIL basic_msb_word: got %b %h expected 1 12345678", wv_m, wo_m);
        else passed++;
        total++;
        if (wv_l !== 1'b1 || wo_l !== 32'h78563412)
            $display("FAIL basic_lsb_word: got %b %h expected 1 78563412", wv_l, wo_l);
        else passed++;
        step(1'b0, 8'h0, 1'b0, 1'b1);
        total++;
        if (wv_m !== 1'b0 || wo_m !== 32'h0 || lvl_m !== 2'd0)
            $display("FAIL basic_pop: got %b %h %0d expected 0 0 0", wv_m, wo_m, lvl_m);
        else passed++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3 * BPW; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        total++;
        if (lvl_m !== 2'd2 || ovf_m !== 1'b1 || ovf_l !== 1'b1)
            $display("FAIL ovf_state: got lvl %0d ovf %b/%b expected 2 1/1", lvl_m, ovf_m, ovf_l);
        else passed++;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (wo_m !== qm[0] || wo_l !== ql[0])
                $display("FAIL ovf_pop%0d: got %h/%h expected %h/%h", i, wo_m, wo_l, qm[0], ql[0]);
            else passed++;
            step(1'b0, 8'h0, 1'b0, 1'b1);
        end
        total++;
        if (wv_m !== 1'b0 || ovf_m !== 1'b1)
            $display("FAIL ovf_sticky: got wv %b ovf %b expected 0 1", wv_m, ovf_m);
        else passed++;
        step(1'b0, 8'h0, 1'b1, 1'b0);
        total++;
        if (ovf_m !== 1'b0 || ovf_l !== 1'b0 || lvl_m !== 2'd0)
            $display("FAIL ovf_flush: got ovf %b/%b lvl %0d expected 0/0 0", ovf_m, ovf_l, lvl_m);
        else passed++;
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 3 * BPW - 1; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'($urandom), 1'b0, 1'b1);
        total++;
        if (ovf_m !== 1'b0 || lvl_m !== 2'd2 || lvl_l !== 2'd2)
            $display("FAIL fullpp_state: got ovf %b lvl %0d/%0d expected 0 2/2", ovf_m, lvl_m, lvl_l);
        else passed++;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (wo_m !== qm[0] || wo_l !== ql[0])
                $display("FAIL fullpp_order%0d: got %h/%h expected %h/%h", i, wo_m, wo_l, qm[0], ql[0]);
            else passed++;
            step(1'b0, 8'h0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_flush_mid();
        step(1'b1, 8'hC1, 1'b0, 1'b0);
        step(1'b1, 8'hC2, 1'b0, 1'b0);
        step(1'b1, 8'hC3, 1'b1, 1'b0);
        total++;
        if (busy_m !== 1'b0 || wv_m !== 1'b0 || tmo_m !== 1'b0)
            $display("FAIL flush_mid: got busy %b wv %b tmo %b expected 0 0 0", busy_m, wv_m, tmo_m);
        else passed++;
        for (int i = 0; i < BPW; i++) step(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
        total++;
        if (wo_m !== 32'hD0D1D2D3 || wo_l !== 32'hD3D2D1D0)
            $display("FAIL flush_restart: got %h/%h expected d0d1d2d3/d3d2d1d0", wo_m, wo_l);
        else passed++;
        step(1'b0, 8'h0, 1'b1, 1'b0);
    endtask

    task automatic test_timeout();
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, 8'h0, 1'b0, 1'b0);
`ifdef RX_ASM_TIMEOUT_EN
            total++;
            if (tmo_m !== (k == TMO) || busy_m !== (k < TMO) || tmo_l !== m_tmo)
                $display("FAIL timeout_cycle%0d: got tmo %b busy %b expected %b %b", k, tmo_m, busy_m, k == TMO, k < TMO);
            else passed++;
`else
            total++;
            if (tmo_m !== 1'b0 || busy_m !== 1'b1)
                $display("FAIL timeout_off%0d: got tmo %b busy %b expected 0 1", k, tmo_m, busy_m);
            else passed++;
`endif
        end
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        total++;
`ifdef RX_ASM_TIMEOUT_EN
        if (wo_m !== 32'h01020304 || wo_l !== ql[0])
            $display("FAIL timeout_next: got %h expected 01020304", wo_m);
        else passed++;
`else
        if (wo_m !== 32'hAABB0102 || wo_l !== ql[0])
            $display("FAIL timeout_next: got %h expected aabb0102", wo_m);
        else passed++;
`endif
        step(1'b0, 8'h0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic bv;
        logic fl;
        for (int c = 0; c < 800; c++) begin
            bv = ($urandom_range(99) < ((c % 200) < 150 ? 60 : 3));
            fl = ($urandom_range(99) < 2);
            step(bv, 8'($urandom), fl, 1'($urandom_range(99) < 40));
            total++;
            if (wv_m !== (qm.size() != 0) || lvl_m !== 2'(qm.size()) || lvl_l !== 2'(ql.size()))
                $display("FAIL rand_level c%0d: got wv %b lvl %0d expected %0d", c, wv_m, lvl_m, qm.size());
            else passed++;
            total++;
            if (wo_m !== (qm.size() != 0 ? qm[0] : 32'h0) || wo_l !== (ql.size() != 0 ? ql[0] : 32'h0))
                $display("FAIL rand_word c%0d: got %h/%h", c, wo_m, wo_l);
            else passed++;
            total++;
            if (busy_m !== (byte_q.size() != 0) || ovf_m !== m_ovf || tmo_m !== m_tmo || busy_l !== busy_m || ovf_l !== m_ovf || tmo_l !== m_tmo)
                $display("FAIL rand_flags c%0d: got busy %b ovf %b tmo %b expected %b %b %b", c, busy_m, ovf_m, tmo_m, byte_q.size() != 0, m_ovf, m_tmo);
            else passed++;
        end
        step(1'b0, 8'h0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < BPW + 2; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        byte_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        total++;
        if ({wv_m, wo_m, lvl_m, busy_m, ovf_m, tmo_m} !== 38'h0 || {wv_l, lvl_l, busy_l} !== 4'h0)
            $display("FAIL reset_mid: got %h expected 0", {wv_m, wo_m, lvl_m, busy_m, ovf_m, tmo_m});
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        for (int i = 0; i < BPW; i++) step(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
        total++;
        if (wo_m !== 32'hE0E1E2E3 || lvl_m !== 2'd1)
            $display("FAIL reset_recover: got %h lvl %0d expected e0e1e2e3 1", wo_m, lvl_m);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_flush_mid();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
